// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: PC, imem read handshake, instruction register, next-PC and halt
//
// Optional feature: define INST_FETCH_ICOUNT_EN to add the icount output
// (number of issued instructions, wraps at 2^32, frozen in HALT).
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   imem_req/imem_addr  one-cycle read request and address (address == pc)
//   imem_rdata/rvalid   read response, only accepted while waiting for it
//   inst/opcode/func    instruction register and its decoder slices
//   inst_valid/ready    issue handshake towards the datapath
//   cB, zero            branch control and ALU zero flag for next-PC selection
//   pc                  address of the instruction held in inst
//   halt                sticky halt indication
//   icount              issued instruction count (INST_FETCH_ICOUNT_EN only)
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [1:0]  cB,
    input  logic        zero,
    output logic [31:0] pc,
`ifdef INST_FETCH_ICOUNT_EN
    output logic [31:0] icount,
`endif
    output logic        halt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        handshake;

    // The request and valid strobes are decoded from the state register but
    // also masked by rst, so they are low for the whole reset period even
    // while the state register already sits in FETCH.
    assign imem_req   = (state == S_FETCH) && !rst;
    assign inst_valid = (state == S_ISSUE) && !rst;
    assign handshake  = inst_valid && inst_ready;

    assign imem_addr = pc;
    assign opcode    = inst[31:26];
    assign func      = inst[5:0];

    always_comb begin
        pc4     = pc + 32'd4;
        br_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
        next_pc = pc4;
        case (cB)
            2'b01:   next_pc = zero ? (pc4 + br_off) : pc4;
            2'b10:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
            default: next_pc = pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            inst  <= 32'd0;
            halt  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst <= imem_rdata;
                        if (imem_rdata[31:26] == HALT_OPCODE) begin
                            state <= S_HALT;
                            halt  <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

`ifdef INST_FETCH_ICOUNT_EN
    // Counts issue handshakes; no handshake is possible in HALT, so the
    // count freezes there without an explicit check.
    always_ff @(posedge clk) begin
        if (rst) begin
            icount <= 32'd0;
        end else if (handshake) begin
            icount <= icount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        inst_valid;
    logic        inst_ready;
    logic [1:0]  cB;
    logic        zero;
    logic [31:0] pc;
    logic        halt;
`ifdef INST_FETCH_ICOUNT_EN
    logic [31:0] icount;
`endif

    inst_fetch_unit #(
        .RESET_PC    (TB_RESET_PC),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .inst        (inst),
        .opcode      (opcode),
        .func        (func),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .cB          (cB),
        .zero        (zero),
        .pc          (pc),
`ifdef INST_FETCH_ICOUNT_EN
        .icount      (icount),
`endif
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;   // expected fetch address
        logic [31:0] data;   // word returned by memory
        int          lat;    // cycles from request to rvalid
        int          stall;  // cycles inst_ready stays low in ISSUE
        logic [1:0]  cb;
        logic        z;
        bit          noise;  // drive a stray rvalid in the FETCH cycle
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t  prog [12];
    exp_t  sb_q [$];
    exp_t  e;
    int    errors = 0;
    int    checks = 0;
    int    exp_icount = 0;
    int    waited;
    bit    halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_icount(input string name, input int exp);
`ifdef INST_FETCH_ICOUNT_EN
        check(name, icount, exp);
`else
        if (exp < 0) $display("unexpected icount %0d", exp);
`endif
    endtask

    task automatic wait_req(output int w);
        w = 0;
        while (imem_req !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("req_seen", imem_req, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // addr, data, lat, stall, cB, zero, noise
        prog[0]  = '{32'h8000_0000, 32'h2008_0005, 1, 0, 2'b00, 1'b0, 1'b0};
        prog[1]  = '{32'h8000_0004, 32'h2008_0005, 1, 0, 2'b00, 1'b0, 1'b0};
        prog[2]  = '{32'h8000_0008, 32'h2008_0005, 1, 0, 2'b11, 1'b1, 1'b0};
        prog[3]  = '{32'h8000_000C, 32'h2008_0005, 5, 4, 2'b00, 1'b0, 1'b1};
        prog[4]  = '{32'h8000_0010, 32'h1000_FFFC, 1, 0, 2'b01, 1'b1, 1'b0};
        prog[5]  = '{32'h8000_0004, 32'h0800_0004, 2, 1, 2'b10, 1'b0, 1'b0};
        prog[6]  = '{32'h8000_0010, 32'h1000_FFFC, 1, 0, 2'b01, 1'b0, 1'b0};
        prog[7]  = '{32'h8000_0014, 32'h0800_0008, 1, 0, 2'b10, 1'b1, 1'b1};
        prog[8]  = '{32'h8000_0020, 32'h0800_0040, 1, 0, 2'b10, 1'b0, 1'b0};
        prog[9]  = '{32'h8000_0100, 32'h1000_0003, 3, 2, 2'b01, 1'b1, 1'b0};
        prog[10] = '{32'h8000_0110, 32'h0000_002A, 1, 0, 2'b00, 1'b1, 1'b0};
        prog[11] = '{32'h8000_0114, 32'hFC00_0000, 1, 0, 2'b00, 1'b0, 1'b0};

        rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        inst_ready = 1'b0; cB = 2'b00; zero = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_pc", pc, TB_RESET_PC);
        check("rst_inst", inst, 32'd0);
        check("rst_halt", halt, 1'b0);
        check_icount("rst_icount", 0);
        rst = 1'b0;
        #1;

        halted = 1'b0;
        for (int i = 0; i < 12 && !halted; i++) begin
            wait_req(waited);
            check($sformatf("gap_%0d", i), waited, 0);
            check($sformatf("addr_%0d", i), imem_addr, prog[i].addr);
            check($sformatf("fetch_valid_%0d", i), inst_valid, 1'b0);
            imem_rvalid = prog[i].noise;
            imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_rvalid = 1'b0;
            for (int k = 1; k < prog[i].lat; k++) begin
                check($sformatf("wait_req_%0d", i), imem_req, 1'b0);
                check($sformatf("wait_valid_%0d", i), inst_valid, 1'b0);
                @(negedge clk);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = prog[i].data;
            sb_q.push_back('{prog[i].addr, prog[i].data});
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
                continue;
            end
            e = sb_q.pop_front();
            check($sformatf("pc_%0d", i), pc, e.pc);
            check($sformatf("inst_%0d", i), inst, e.inst);
            if (e.inst[31:26] == 6'b111111) begin
                halted = 1'b1;
                check("halt_flag", halt, 1'b1);
                check("halt_valid", inst_valid, 1'b0);
                continue;
            end
            check($sformatf("valid_%0d", i), inst_valid, 1'b1);
            check($sformatf("opcode_%0d", i), opcode, {26'd0, e.inst[31:26]});
            check($sformatf("func_%0d", i), func, {26'd0, e.inst[5:0]});
            for (int s = 0; s < prog[i].stall; s++) begin
                inst_ready  = 1'b0;
                cB          = 2'b10;
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
                @(negedge clk);
                check($sformatf("hold_valid_%0d", i), inst_valid, 1'b1);
                check($sformatf("hold_req_%0d", i), imem_req, 1'b0);
                check($sformatf("hold_inst_%0d", i), inst, e.inst);
                check($sformatf("hold_pc_%0d", i), pc, e.pc);
            end
            imem_rvalid = 1'b0;
            inst_ready  = 1'b1;
            cB          = prog[i].cb;
            zero        = prog[i].z;
            exp_icount++;
            @(negedge clk);
            inst_ready = 1'b0;
            cB         = 2'b00;
            zero       = 1'b0;
        end
        check("halt_reached", halted, 1'b1);

        // HALT must ignore everything except reset.
        for (int c = 0; c < 6; c++) begin
            inst_ready  = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h2008_0005;
            @(negedge clk);
            check("halt_req", imem_req, 1'b0);
            check("halt_valid_hold", inst_valid, 1'b0);
            check("halt_sticky", halt, 1'b1);
            check("halt_pc", pc, 32'h8000_0114);
            check("halt_inst", inst, 32'hFC00_0000);
        end
        check_icount("icount_halt", exp_icount);
        inst_ready = 1'b0; imem_rvalid = 1'b0;

        // Reset out of HALT, then reset again in the middle of WAIT while a
        // response is arriving in the same cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_req", imem_req, 1'b1);
        check("rst2_addr", imem_addr, TB_RESET_PC);
        check("rst2_halt", halt, 1'b0);
        check("rst2_inst", inst, 32'd0);
        check_icount("rst2_icount", 0);
        @(negedge clk);
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        check("rstwait_req", imem_req, 1'b0);
        check("rstwait_valid", inst_valid, 1'b0);
        rst = 1'b0; imem_rvalid = 1'b0;
        #1;
        check("rst3_req", imem_req, 1'b1);
        check("rst3_addr", imem_addr, TB_RESET_PC);
        check("rst3_inst", inst, 32'd0);
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("rst3_valid", inst_valid, 1'b1);
        check("rst3_inst_loaded", inst, 32'h2008_0005);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("rst3_next_addr", imem_addr, TB_RESET_PC + 32'd4);
        check_icount("rst3_icount", 1);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
